axi4_wr_burst_sched: RTL
========================

// Module: axi4_wr_burst_sched
// PURPOSE
//  Write-side scheduler between the stream-packing FIFO and the AXI4 memory port.
//  Watches the FIFO fill count and issues fixed-length AXI4 INCR write bursts.
//  Drains FIFO words onto the W channel and collects B responses.
//  Advances a linear frame-buffer offset that wraps at frame end.
// PARAMETERS
//  FAW              8        FIFO depth is 2^FAW; the count is FAW+1 bits
//  AXI4_DATA_WIDTH  128      W data width, equal to the FIFO word width
//  AXI_ADDR_WIDTH   32       AWADDR width
//  BURST_LEN        16       beats per burst (1..256); AWLEN = BURST_LEN-1
//  FRAME_BYTES      8294400  bytes per frame; must be a multiple of BURST_LEN*AXI4_DATA_WIDTH/8
// PORTS
//  M_AXI_ACLK     in   1    single clock
//  M_AXI_ARESETN  in   1    asynchronous reset, active low
//  enable         in   1    level; allows new bursts to start
//  base_addr      in   AXI_ADDR_WIDTH   frame buffer base, aligned to burst bytes; sampled per burst
//  fifo_cnt       in   FAW+1            FIFO occupancy in words
//  fifo_dat       in   AXI4_DATA_WIDTH  FIFO head word (first-word-fall-through)
//  fifo_rd        out  1    FIFO pop, = M_AXI_WVALID & M_AXI_WREADY
//  M_AXI_AWADDR   out  AXI_ADDR_WIDTH   burst address
//  M_AXI_AWLEN    out  8    BURST_LEN-1, constant
//  M_AXI_AWSIZE   out  3    clog2(AXI4_DATA_WIDTH/8), constant
//  M_AXI_AWBURST  out  2    2'b01 (INCR), constant
//  M_AXI_AWVALID  out  1    address valid
//  M_AXI_AWREADY  in   1    address accepted
//  M_AXI_WDATA    out  AXI4_DATA_WIDTH  = fifo_dat
//  M_AXI_WSTRB    out  AXI4_DATA_WIDTH/8  all ones
//  M_AXI_WLAST    out  1    last beat of burst
//  M_AXI_WVALID   out  1    write data valid
//  M_AXI_WREADY   in   1    write data accepted
//  M_AXI_BRESP    in   2    write response
//  M_AXI_BVALID   in   1    response valid
//  M_AXI_BREADY   out  1    response ready
//  frame_done     out  1    one-cycle pulse when the last burst of a frame is acknowledged
//  done_buf       out  1    buffer index of the frame just completed (see CONFIGURATION)
//  wr_err         out  1    sticky; set on any BRESP != 2'b00, cleared only by reset
// BEHAVIOUR
//  Reset: state=IDLE; offset=0; beat_cnt=0; buf_sel=0.
//   AWVALID, WVALID, WLAST, BREADY, frame_done, done_buf and wr_err = 0; AWADDR = 0.
//  FSM IDLE -> ADDR -> DATA -> RESP -> IDLE.
//  IDLE: if enable & (fifo_cnt >= BURST_LEN), register AWADDR = base_addr + buf_off + offset
//   and set AWVALID=1 next cycle (state ADDR). Otherwise stay.
//  ADDR: hold AWVALID and AWADDR stable until AWREADY; on handshake AWVALID=0 -> DATA.
//  DATA: WVALID=1 every cycle (FIFO already holds >= BURST_LEN words; the writer only adds).
//   beat_cnt increments on each W handshake. WLAST = (beat_cnt == BURST_LEN-1).
//   On the WLAST handshake: beat_cnt=0, WVALID=0 -> RESP. WVALID is never dropped mid-burst.
//  RESP: BREADY=1; on BVALID: wr_err |= (BRESP != 0);
//   offset += BURST_LEN*AXI4_DATA_WIDTH/8; if that sum == FRAME_BYTES then offset=0 and
//   frame_done=1 for one cycle; -> IDLE. First address after a response is >= 1 cycle later.
//  Error responses do not retry or stall; the offset still advances.
//  enable low mid-burst: current burst runs through RESP; no new burst starts.
//  fifo_cnt == BURST_LEN exactly is sufficient to start; fifo_cnt max 2^FAW is legal.
//  Aligned base and power-of-2 burst bytes <= 4096: no burst crosses a 4 KB boundary.
//  Async reset mid-burst returns everything to reset values immediately. The partial
//   AXI transaction is abandoned; the interconnect is reset on the same net.
//  Offset width: clog2(FRAME_BYTES)+1 bits; address add is modulo 2^AXI_ADDR_WIDTH.
// CONFIGURATION
//  WR_PINGPONG_EN defined:
//   buf_off = buf_sel ? FRAME_BYTES : 0. At frame wrap, done_buf <= buf_sel, then buf_sel toggles.
//   Frames alternate between base_addr and base_addr+FRAME_BYTES.
//  WR_PINGPONG_EN undefined:
//   buf_off = 0; buf_sel and done_buf held at 0; every frame rewrites base_addr.
// TESTING
//  T1 BURST_LEN=16, 128b, base 0x1000_0000, fifo_cnt 15 -> no AWVALID.
//     fifo_cnt 16 -> AWADDR 0x1000_0000, AWLEN 15, AWSIZE 4, AWBURST 1.
//  T2 AWREADY held low 10 cycles -> AWADDR/AWVALID stable; then 16 W beats.
//     WREADY toggled randomly; WLAST only on beat 16; fifo_rd count = 16.
//  T3 FRAME_BYTES=1024, continuous data -> AWADDR 0x000,0x100,0x200,0x300,0x000.
//     frame_done pulses once, 1 cycle, on the 4th BVALID.
//  T4 BRESP=2'b10 on burst 2 -> wr_err=1 and stays 1. Next AWADDR still advances by 0x100.
//  T5 enable dropped during DATA beat 5 -> burst completes with 16 beats and B;
//     no new AWVALID while enable=0. Reset asserted mid-DATA -> all outputs 0; next AWADDR = base.
//  T6 WR_PINGPONG_EN, FRAME_BYTES=1024 -> frame 2 starts at base+0x400.
//     done_buf=0 after frame 1, 1 after frame 2; frame 3 returns to base.

Source files
------------

// File: rtl/axi4_wr_burst_sched_if.sv
// AXI4 write-channel bundle (AW, W, B) between the burst scheduler and the memory port.
interface axi4_wr_burst_sched_if #(
  parameter int unsigned AXI4_DATA_WIDTH = 128,
  parameter int unsigned AXI_ADDR_WIDTH  = 32
);
  logic [AXI_ADDR_WIDTH-1:0]    AWADDR;
  logic [7:0]                   AWLEN;
  logic [2:0]                   AWSIZE;
  logic [1:0]                   AWBURST;
  logic                         AWVALID;
  logic                         AWREADY;
  logic [AXI4_DATA_WIDTH-1:0]   WDATA;
  logic [AXI4_DATA_WIDTH/8-1:0] WSTRB;
  logic                         WLAST;
  logic                         WVALID;
  logic                         WREADY;
  logic [1:0]                   BRESP;
  logic                         BVALID;
  logic                         BREADY;

  modport master (
    output AWADDR, AWLEN, AWSIZE, AWBURST, AWVALID, WDATA, WSTRB, WLAST, WVALID, BREADY,
    input  AWREADY, WREADY, BRESP, BVALID
  );

  modport slave (
    input  AWADDR, AWLEN, AWSIZE, AWBURST, AWVALID, WDATA, WSTRB, WLAST, WVALID, BREADY,
    output AWREADY, WREADY, BRESP, BVALID
  );
endinterface

// File: rtl/axi4_wr_burst_sched.sv
// Write-burst scheduler: drains a FWFT FIFO into fixed-length AXI4 INCR bursts over a frame buffer.
// Define WR_PINGPONG_EN to alternate frames between base_addr and base_addr+FRAME_BYTES.
module axi4_wr_burst_sched #(
  parameter int unsigned FAW             = 8,
  parameter int unsigned AXI4_DATA_WIDTH = 128,
  parameter int unsigned AXI_ADDR_WIDTH  = 32,
  parameter int unsigned BURST_LEN       = 16,
  parameter int unsigned FRAME_BYTES     = 8294400
) (
  input  logic                       M_AXI_ACLK,
  input  logic                       M_AXI_ARESETN,
  input  logic                       enable,
  input  logic [AXI_ADDR_WIDTH-1:0]  base_addr,
  input  logic [FAW:0]               fifo_cnt,
  input  logic [AXI4_DATA_WIDTH-1:0] fifo_dat,
  output logic                       fifo_rd,
  axi4_wr_burst_sched_if.master      m_axi,
  output logic                       frame_done,
  output logic                       done_buf,
  output logic                       wr_err
);

  localparam int unsigned BurstBytes = BURST_LEN * AXI4_DATA_WIDTH / 8;
  localparam int unsigned OffW       = $clog2(FRAME_BYTES) + 1;
  localparam int unsigned BeatW      = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1;
  localparam int unsigned SizeEnc    = $clog2(AXI4_DATA_WIDTH / 8);

  typedef enum logic [1:0] {StIdle, StAddr, StData, StResp} state_e;

  state_e                    r_state, w_state_d;
  logic [OffW-1:0]           r_offset, w_offset_d, w_off_sum;
  logic [BeatW-1:0]          r_beat_cnt, w_beat_cnt_d;
  logic [AXI_ADDR_WIDTH-1:0] r_awaddr, w_awaddr_d, w_buf_off;
  logic                      r_frame_done, w_frame_done_d;
  logic                      r_wr_err, w_wr_err_d;
  logic                      w_start, w_last, w_frame_wrap, w_wvalid;

  assign w_start      = enable && (32'(fifo_cnt) >= BURST_LEN);
  assign w_wvalid     = (r_state == StData);
  assign w_last       = w_wvalid && (r_beat_cnt == BeatW'(BURST_LEN - 1));
  assign w_off_sum    = r_offset + OffW'(BurstBytes);
  assign w_frame_wrap = (w_off_sum == OffW'(FRAME_BYTES));

`ifdef WR_PINGPONG_EN
  logic r_buf_sel, r_done_buf;

  // Buffer index flips on the response that closes a frame.
  always_ff @(posedge M_AXI_ACLK or negedge M_AXI_ARESETN) begin
    if (!M_AXI_ARESETN) begin
      r_buf_sel  <= 1'b0;
      r_done_buf <= 1'b0;
    end else if ((r_state == StResp) && m_axi.BVALID && w_frame_wrap) begin
      r_done_buf <= r_buf_sel;
      r_buf_sel  <= ~r_buf_sel;
    end
  end

  assign w_buf_off = r_buf_sel ? AXI_ADDR_WIDTH'(FRAME_BYTES) : '0;
  assign done_buf  = r_done_buf;
`else
  assign w_buf_off = '0;
  assign done_buf  = 1'b0;
`endif

  always_ff @(posedge M_AXI_ACLK or negedge M_AXI_ARESETN) begin
    if (!M_AXI_ARESETN) begin
      r_state <= StIdle;
    end else begin
      r_state <= w_state_d;
    end
  end

  always_comb begin
    w_state_d      = r_state;
    w_offset_d     = r_offset;
    w_beat_cnt_d   = r_beat_cnt;
    w_awaddr_d     = r_awaddr;
    w_frame_done_d = 1'b0;
    w_wr_err_d     = r_wr_err;
    unique case (r_state)
      StIdle: begin
        if (w_start) begin
          w_awaddr_d = base_addr + w_buf_off + AXI_ADDR_WIDTH'(r_offset);
          w_state_d  = StAddr;
        end
      end
      StAddr: begin
        if (m_axi.AWREADY) w_state_d = StData;
      end
      StData: begin
        if (m_axi.WREADY) begin
          if (w_last) begin
            w_beat_cnt_d = '0;
            w_state_d    = StResp;
          end else begin
            w_beat_cnt_d = r_beat_cnt + BeatW'(1);
          end
        end
      end
      StResp: begin
        if (m_axi.BVALID) begin
          w_wr_err_d = r_wr_err | (m_axi.BRESP != 2'b00);
          // Error responses still advance the offset; nothing is retried.
          if (w_frame_wrap) begin
            w_offset_d     = '0;
            w_frame_done_d = 1'b1;
          end else begin
            w_offset_d = w_off_sum;
          end
          w_state_d = StIdle;
        end
      end
      default: w_state_d = StIdle;
    endcase
  end

  always_ff @(posedge M_AXI_ACLK or negedge M_AXI_ARESETN) begin
    if (!M_AXI_ARESETN) begin
      r_offset     <= '0;
      r_beat_cnt   <= '0;
      r_awaddr     <= '0;
      r_frame_done <= 1'b0;
      r_wr_err     <= 1'b0;
    end else begin
      r_offset     <= w_offset_d;
      r_beat_cnt   <= w_beat_cnt_d;
      r_awaddr     <= w_awaddr_d;
      r_frame_done <= w_frame_done_d;
      r_wr_err     <= w_wr_err_d;
    end
  end

  assign m_axi.AWADDR  = r_awaddr;
  assign m_axi.AWLEN   = 8'(BURST_LEN - 1);
  assign m_axi.AWSIZE  = 3'(SizeEnc);
  assign m_axi.AWBURST = 2'b01;
  assign m_axi.AWVALID = (r_state == StAddr);
  assign m_axi.WDATA   = fifo_dat;
  assign m_axi.WSTRB   = '1;
  assign m_axi.WLAST   = w_last;
  assign m_axi.WVALID  = w_wvalid;
  assign m_axi.BREADY  = (r_state == StResp);

  assign fifo_rd    = w_wvalid & m_axi.WREADY;
  assign frame_done = r_frame_done;
  assign wr_err     = r_wr_err;

endmodule
